gen_streams: RTL and testbench
==============================

GEN_STREAMS -- requirements
Module: gen_streams

Interface
REQ-001 SHALL have parameter WRITE_STREAM_MAXSIZE, default 230400, stream length in 32-bit words (multiple of 16*BURST_BEATS).
REQ-002 SHALL have parameter STREAM_ADDR_OFFSET, default $clog2(WRITE_STREAM_MAXSIZE), word-address bit where the stream number starts.
REQ-003 SHALL have parameter STREAM_ADDR_SHIFT, default 2, word-to-byte address shift.
REQ-004 SHALL have parameter BURST_BEATS, default 64, beats per AXI burst (64 B per beat, 4 KB per burst).
REQ-005 SHALL have ports: clk in 1 (single clock); reset in 1 (asynchronous, active-low).
REQ-006 SHALL have ports: start in 1, begin run; num_streams in 8, streams per run; iter_num in 8, iteration tag.
REQ-007 SHALL have AW ports: AWADDR out 32; AWLEN out 8; AWSIZE out 3; AWBURST out 2; AWVALID out 1; AWREADY in 1.
REQ-008 SHALL have W ports: WDATA out 512; WSTRB out 64; WLAST out 1; WVALID out 1; WREADY in 1.
REQ-009 SHALL have B ports: BRESP in 2; BVALID in 1; BREADY out 1.
REQ-010 SHALL have status ports: busy out 1; done out 1, one-cycle pulse; error_detect out 1, sticky.

Function
REQ-011 SHALL implement FSM IDLE -> AW -> W -> B; B -> AW for the next burst, or B -> IDLE with done=1 for one cycle after the final burst.
REQ-012 SHALL, in IDLE, accept start only when busy=0, latch num_streams and iter_num, clear error_detect, and enter AW on the next cycle; start while busy is ignored.
REQ-013 SHALL, when start arrives with num_streams=0, pulse done on the next cycle without asserting AWVALID.
REQ-014 SHALL drive AWADDR = (s << (STREAM_ADDR_SHIFT+STREAM_ADDR_OFFSET)) + b*BURST_BEATS*64 for stream s and burst b, with AWLEN=BURST_BEATS-1, AWSIZE=3'b110 and AWBURST=2'b01.
REQ-015 SHALL hold AWVALID and all AW fields stable until the AWREADY handshake.
REQ-016 SHALL assert WVALID only after the AW handshake and hold WDATA, WLAST and WVALID stable until WREADY; WSTRB is all ones.
REQ-017 SHALL set WDATA 32-bit word i (i=0..15, word 0 at bits [31:0]) = {s[7:0], iter_num[7:0], cnt+i}, using 16-bit modulo arithmetic.
REQ-018 SHALL reset the 16-bit cnt to 0 at the start of each stream and add 16 (wrapping mod 2^16) on each W handshake.
REQ-019 SHALL assert WLAST on beat BURST_BEATS-1 of every burst.
REQ-020 SHALL assert BREADY only in state B and leave B after the BVALID&BREADY handshake.
REQ-021 SHALL set error_detect=1 on any B handshake with BRESP!=2'b00, keep it set until the next accepted start, and continue generation.
REQ-022 SHALL issue WRITE_STREAM_MAXSIZE/(16*BURST_BEATS) bursts per stream and streams 0..num_streams-1 in order, with one burst outstanding.
REQ-023 SHALL hold busy=1 from the cycle after start is accepted until the cycle done is asserted.

Reset
REQ-024 SHALL, on reset=0, immediately clear the FSM to IDLE and drive AWVALID, WVALID, WLAST, BREADY, busy, done, error_detect, AWADDR and WDATA to 0, abandoning any in-flight burst.
REQ-025 SHALL respond to start normally on the first clk edge after reset is released.

Configuration
REQ-026 SHALL, when GEN_STREAMS_ERR_INJECT_EN is defined, add input inject_err (1 bit); a pulse arms a one-shot that inverts bit 0 of the next handshaken W beat, then disarms.
REQ-027 SHALL, when GEN_STREAMS_ERR_INJECT_EN is undefined, omit the inject_err port and always emit the exact pattern.

Verification
REQ-028 SHALL cover: start, num_streams=1, iter_num=0x05, all READYs high -> 225 bursts at AWADDR 0x0, 0x1000, ... 0xE0000; beat0 word0=0x00050000, word15=0x0005000F; done after the 225th B.
REQ-029 SHALL cover: num_streams=2 -> second stream's first AWADDR=0x00100000, beat0 word0=0x01050000 (cnt restarted); busy falls with done.
REQ-030 SHALL cover: random WREADY/AWREADY stalls -> W/AW signals stable while stalled; beat 4096 of stream 0 word0=0x00050000 (cnt wrap).
REQ-031 SHALL cover: BRESP=2'b10 on burst 3 -> error_detect=1 sticky, all 225 bursts still issued, error_detect cleared by the next start.
REQ-032 SHALL cover: reset low mid-W burst -> all outputs 0 asynchronously; later start with num_streams=0 -> done pulse, AWVALID never asserted.
REQ-033 SHALL cover, with GEN_STREAMS_ERR_INJECT_EN defined: inject_err pulse -> exactly one beat with word0 bit 0 inverted, all later beats correct.

Source files
------------

// File: rtl/gen_streams.sv
// gen_streams: AXI4 write master that streams a counter pattern into num_streams regions.
// Define GEN_STREAMS_ERR_INJECT_EN to add inject_err (one-shot bit-0 corruption of a W beat).
module gen_streams #(
    parameter int WRITE_STREAM_MAXSIZE = 230400,
    parameter int STREAM_ADDR_OFFSET   = $clog2(WRITE_STREAM_MAXSIZE),
    parameter int STREAM_ADDR_SHIFT    = 2,
    parameter int BURST_BEATS          = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   num_streams,
    input  logic [7:0]   iter_num,
`ifdef GEN_STREAMS_ERR_INJECT_EN
    input  logic         inject_err,
`endif
    output logic [31:0]  AWADDR,
    output logic [7:0]   AWLEN,
    output logic [2:0]   AWSIZE,
    output logic [1:0]   AWBURST,
    output logic         AWVALID,
    input  logic         AWREADY,
    output logic [511:0] WDATA,
    output logic [63:0]  WSTRB,
    output logic         WLAST,
    output logic         WVALID,
    input  logic         WREADY,
    input  logic [1:0]   BRESP,
    input  logic         BVALID,
    output logic         BREADY,
    output logic         busy,
    output logic         done,
    output logic         error_detect
);

    localparam int BURSTS      = WRITE_STREAM_MAXSIZE / (16 * BURST_BEATS);
    localparam int BURST_W     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int BURST_BYTES = BURST_BEATS * 64;
    localparam int ADDR_SH     = STREAM_ADDR_SHIFT + STREAM_ADDR_OFFSET;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    function automatic logic [31:0] f_addr(input logic [7:0] s, input logic [BURST_W-1:0] b);
        return (32'(s) << ADDR_SH) + 32'(b) * 32'(BURST_BYTES);
    endfunction

    function automatic logic [511:0] f_beat(input logic [7:0] s, input logic [7:0] it,
                                            input logic [15:0] c);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = {s, it, c + 16'(i)};
        return d;
    endfunction

    logic [1:0]         r_state;
    logic [7:0]         r_num;
    logic [7:0]         r_iter;
    logic [7:0]         r_stream;
    logic [BURST_W-1:0] r_burst;
    logic [BEAT_W-1:0]  r_beat;
    logic [15:0]        r_cnt;
    logic [31:0]        r_awaddr;
    logic               r_awvalid;
    logic [511:0]       r_wdata;
    logic               r_wlast;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_last_burst;
    logic               w_last_stream;
    logic [31:0]        w_next_addr;
    logic               w_load;
    logic [15:0]        w_load_cnt;
    logic [511:0]       w_load_data;
    logic               w_inj;

    assign w_last_burst  = (r_burst == BURST_W'(BURSTS - 1));
    assign w_last_stream = (r_stream == r_num - 8'd1);
    assign w_next_addr   = w_last_burst ? f_addr(r_stream + 8'd1, '0)
                                        : f_addr(r_stream, r_burst + BURST_W'(1));
    // A beat is loaded into the W register on the AW handshake and on each non-final W handshake.
    assign w_load      = (r_state == S_AW && AWREADY) || (r_state == S_W && WREADY && !r_wlast);
    assign w_load_cnt  = (r_state == S_AW) ? r_cnt : r_cnt + 16'd16;
    assign w_load_data = f_beat(r_stream, r_iter, w_load_cnt) ^ {511'd0, w_inj};

`ifdef GEN_STREAMS_ERR_INJECT_EN
    logic r_inj_armed;
    assign w_inj = (r_inj_armed | inject_err) & w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_inj_armed <= 1'b0;
        else        r_inj_armed <= (r_inj_armed | inject_err) & ~w_load;
    end
`else
    assign w_inj = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_iter    <= '0;
            r_stream  <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_num    <= num_streams;
                    r_iter   <= iter_num;
                    r_err    <= 1'b0;
                    r_stream <= '0;
                    r_burst  <= '0;
                    r_beat   <= '0;
                    r_cnt    <= '0;
                    r_awaddr <= '0;
                    if (num_streams == 8'd0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state   <= S_AW;
                        r_awvalid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_AW: if (AWREADY) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_wdata   <= w_load_data;
                    r_wlast   <= (BURST_BEATS == 1);
                    r_beat    <= '0;
                    r_state   <= S_W;
                end
                S_W: if (WREADY) begin
                    r_cnt <= r_cnt + 16'd16;
                    if (r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end else begin
                        r_wdata <= w_load_data;
                        r_beat  <= r_beat + BEAT_W'(1);
                        r_wlast <= ((r_beat + BEAT_W'(1)) == BEAT_W'(BURST_BEATS - 1));
                    end
                end
                S_B: if (BVALID) begin
                    r_bready <= 1'b0;
                    if (BRESP != 2'b00) r_err <= 1'b1;
                    if (w_last_burst && w_last_stream) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= S_AW;
                        r_awvalid <= 1'b1;
                        r_awaddr  <= w_next_addr;
                        if (w_last_burst) begin
                            r_stream <= r_stream + 8'd1;
                            r_burst  <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_burst <= r_burst + BURST_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AWADDR       = r_awaddr;
    assign AWLEN        = 8'(BURST_BEATS - 1);
    assign AWSIZE       = 3'b110;
    assign AWBURST      = 2'b01;
    assign AWVALID      = r_awvalid;
    assign WDATA        = r_wdata;
    assign WSTRB        = '1;
    assign WLAST        = r_wlast;
    assign WVALID       = r_wvalid;
    assign BREADY       = r_bready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error_detect = r_err;

endmodule

// File: tb/tb_gen_streams.sv
// Scoreboard bench for gen_streams: expected AW addresses and W beats queued at start.
module tb_gen_streams;

    localparam int BURSTS = 225;
    localparam int BEATS  = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_streams = '0;
    logic [7:0]   iter_num = '0;
`ifdef GEN_STREAMS_ERR_INJECT_EN
    logic         inject_err = 1'b0;
`endif
    logic [31:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST;
    logic         AWVALID;
    logic         AWREADY = 1'b1;
    logic [511:0] WDATA;
    logic [63:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY = 1'b1;
    logic [1:0]   BRESP = 2'b00;
    logic         BVALID = 1'b0;
    logic         BREADY;
    logic         busy;
    logic         done;
    logic         error_detect;

    gen_streams dut (
        .clk(clk), .reset(reset), .start(start), .num_streams(num_streams),
        .iter_num(iter_num),
`ifdef GEN_STREAMS_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .busy(busy), .done(done), .error_detect(error_detect)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [527:0] got, input logic [527:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beat k of a stream: word i = {s, iter, 16*k+i mod 2^16}; bit 512 is WLAST.
    function automatic logic [527:0] exp_beat(input int s, input logic [7:0] it, input int k);
        logic [527:0] v;
        logic [15:0]  c;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            c = 16'((k * 16 + i) % 65536);
            v[32*i +: 32] = {8'(s), it, c};
        end
        v[512] = ((k % BEATS) == BEATS - 1);
        return v;
    endfunction

    logic [31:0]  aw_q[$];
    logic [527:0] w_q[$];
    bit           mon_en = 1'b0;
    bit           stall = 1'b0;
    int           err_burst = -1;
    int           b_cnt = 0, exp_bursts = 0, done_cnt = 0, aw_hs = 0, wb_done = 0;
    int           aw_idx = 0, w_idx = 0, aw_high_cnt = 0, inj_seen = 0;
    bit           exp_err = 1'b0, inj_pending = 1'b0;
    logic [31:0]  cap_w0_0, cap_w0_15, cap_w4096, cap_w14400, cap_a224, cap_a225;

    // Ready/response driver, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        AWREADY = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        WREADY  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        BVALID  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        BRESP   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
    end

    always @(negedge clk) begin : mon
        logic [31:0]  ea;
        logic [527:0] ew;
        logic [45:0]  aw_prev;
        logic [513:0] w_prev;
        bit           aw_stall_q, w_stall_q;
        if (mon_en) begin
            if (aw_stall_q) check_eq("aw_hold", {AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST}, aw_prev);
            if (w_stall_q) check_eq("w_hold", {WVALID, WLAST, WDATA}, w_prev);
            aw_stall_q = AWVALID && !AWREADY;
            w_stall_q  = WVALID && !WREADY;
            aw_prev    = {AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST};
            w_prev     = {WVALID, WLAST, WDATA};
            if (AWVALID) aw_high_cnt++;
            if (AWVALID && AWREADY) begin
                check_eq("aw_expected", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) begin
                    ea = aw_q.pop_front();
                    check_eq("awaddr", AWADDR, ea);
                end
                check_eq("aw_fields", {AWLEN, AWSIZE, AWBURST}, {8'd63, 3'b110, 2'b01});
                check_eq("err_sticky", error_detect, exp_err);
                if (aw_idx == 224) cap_a224 = AWADDR;
                if (aw_idx == 225) cap_a225 = AWADDR;
                aw_idx++;
                aw_hs++;
            end
            if (WVALID && WREADY) begin
                check_eq("w_after_aw", aw_hs > wb_done, 1);
                check_eq("wstrb", WSTRB, {64{1'b1}});
                check_eq("bready_low_in_w", BREADY, 0);
                check_eq("w_expected", w_q.size() != 0, 1);
                if (w_q.size() != 0) begin
                    ew = w_q.pop_front();
                    if (inj_pending && {WLAST, WDATA} == (ew ^ 528'd1)) begin
                        inj_pending = 1'b0;
                        inj_seen++;
                        check_eq("w_inject", {WLAST, WDATA}, ew ^ 528'd1);
                    end else begin
                        check_eq("w_beat", {WLAST, WDATA}, ew);
                    end
                end
                if (w_idx == 0) begin
                    cap_w0_0  = WDATA[31:0];
                    cap_w0_15 = WDATA[511:480];
                end
                if (w_idx == 4096) cap_w4096 = WDATA[31:0];
                if (w_idx == 14400) cap_w14400 = WDATA[31:0];
                w_idx++;
                if (WLAST) wb_done++;
            end
            if (BVALID && BREADY) begin
                if (BRESP != 2'b00) exp_err = 1'b1;
                b_cnt++;
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", busy, 0);
                check_eq("bursts_at_done", b_cnt, exp_bursts);
                check_eq("err_at_done", error_detect, exp_err);
            end
        end else begin
            aw_stall_q = 1'b0;
            w_stall_q  = 1'b0;
        end
    end

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic kick(input logic [7:0] ns, input logic [7:0] it);
        aw_q.delete();
        w_q.delete();
        for (int s = 0; s < int'(ns); s++) begin
            for (int bi = 0; bi < BURSTS; bi++) begin
                aw_q.push_back(32'(s) * 32'h0010_0000 + 32'(bi) * 32'h1000);
                for (int j = 0; j < BEATS; j++) w_q.push_back(exp_beat(s, it, bi * BEATS + j));
            end
        end
        exp_bursts = int'(ns) * BURSTS;
        exp_err = 1'b0;
        {b_cnt, aw_idx, w_idx, aw_hs, wb_done, aw_high_cnt} = '0;
        {cap_w0_0, cap_w0_15, cap_w4096, cap_w14400} = {4{32'hDEAD_BEEF}};
        {cap_a224, cap_a225} = {2{32'hDEAD_BEEF}};
        start = 1'b1;
        num_streams = ns;
        iter_num = it;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (ns != 0) check_eq("busy_after_start", {busy, done}, 2'b10);
        else check_eq("done_zero_streams", {done, busy, AWVALID}, 3'b100);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt != d0) ok = 1'b1;
        end
        check_eq("done_seen", ok, 1);
        check_eq("aw_q_drained", aw_q.size(), 0);
        check_eq("w_q_drained", w_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", {AWVALID, WVALID, WLAST, BREADY, busy, done, error_detect,
                                 AWADDR, WDATA}, '0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Two streams, all ready; a stray start mid-run must be ignored.
        kick(8'd2, 8'h05);
`ifdef GEN_STREAMS_ERR_INJECT_EN
        repeat (20) @(posedge clk);
        #1;
        inj_pending = 1'b1;
        inject_err = 1'b1;
        @(posedge clk);
        #1;
        inject_err = 1'b0;
`endif
        repeat (100) @(posedge clk);
        #1;
        start = 1'b1;
        num_streams = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40000);
        check_eq("s0_b0_word0", cap_w0_0, 32'h0005_0000);
        check_eq("s0_b0_word15", cap_w0_15, 32'h0005_000F);
        check_eq("s0_last_awaddr", cap_a224, 32'h000E_0000);
        check_eq("s1_first_awaddr", cap_a225, 32'h0010_0000);
        check_eq("s1_b0_word0", cap_w14400, 32'h0105_0000);
        check_eq("cnt_wrap_word0", cap_w4096, 32'h0005_0000);
`ifdef GEN_STREAMS_ERR_INJECT_EN
        check_eq("inject_once", inj_seen, 1);
`endif

        // Random stalls with an error response on burst 3.
        stall = 1'b1;
        err_burst = 3;
        kick(8'd1, 8'h05);
        wait_done(40000);
        check_eq("stall_wrap_word0", cap_w4096, 32'h0005_0000);
        check_eq("stall_last_awaddr", cap_a224, 32'h000E_0000);
        check_eq("err_set_after_run", error_detect, 1);
        stall = 1'b0;
        err_burst = -1;
        kick(8'd0, 8'h09);
        check_eq("err_cleared", error_detect, 0);
        wait_done(10);

        // Reset in the middle of the second burst's W phase.
        err_burst = 0;
        kick(8'd1, 8'h05);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (w_idx >= 70 && WVALID) hit = 1'b1;
        end
        check_eq("reached_mid_w", hit, 1);
        check_eq("err_before_reset", error_detect, 1);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_clear", {AWVALID, WVALID, WLAST, BREADY, busy, done, error_detect,
                                       AWADDR, WDATA}, '0);
        err_burst = -1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;
        kick(8'd0, 8'h00);
        repeat (20) @(negedge clk);
        check_eq("no_awvalid_zero_run", aw_high_cnt, 0);
        check_eq("idle_after_zero_run", {busy, done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
